// File: rtl/sys_defs.sv
// Shared definitions for the processor-memory bus: command encodings,
// the transaction-ownership record and arbiter defaults.
package sys_defs;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  // One entry per memory tag: is a load outstanding, and which cache owns it.
  typedef struct packed {
    logic valid;
    logic is_icache;
  } MEM_OWNER_t;

  localparam int ARB_STARVE_LIMIT = 4;
  localparam int ARB_NUM_MEM_TAGS = 16;

endpackage

// File: rtl/mem_owner_table.sv
// Tag-indexed table recording which cache owns each outstanding load.
// A free and an allocation of the same tag in one cycle leave the entry
// allocated to the new owner, because memory may recycle a tag the very
// cycle it returns data for it.
module mem_owner_table
  import sys_defs::*;
#(
  parameter int NUM_MEM_TAGS = ARB_NUM_MEM_TAGS,
  localparam int TAG_W = $clog2(NUM_MEM_TAGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en_i,
  input  logic [TAG_W-1:0] alloc_tag_i,
  input  logic             alloc_is_icache_i,
  input  logic             free_en_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output MEM_OWNER_t       lookup_entry_o
);

  MEM_OWNER_t owner_q [NUM_MEM_TAGS];
  MEM_OWNER_t owner_d [NUM_MEM_TAGS];

  // Lookup is a plain read of the registered table.
  assign lookup_entry_o = owner_q[lookup_tag_i];

  // Next table: free the returning tag first, then let allocation override.
  always_comb begin
    for (int i = 0; i < NUM_MEM_TAGS; i++) begin
      owner_d[i] = owner_q[i];
    end
    if (free_en_i) begin
      owner_d[lookup_tag_i].valid = 1'b0;
    end
    if (alloc_en_i) begin
      owner_d[alloc_tag_i].valid     = 1'b1;
      owner_d[alloc_tag_i].is_icache = alloc_is_icache_i;
    end
  end

  // Table register; reset discards all outstanding ownership.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_MEM_TAGS; i++) begin
      if (reset) begin
        owner_q[i] <= '0;
      end else begin
        owner_q[i] <= owner_d[i];
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory port between Icache and Dcache.
// Dcache normally wins; Icache wins outright once it has been denied or
// rejected STARVE_LIMIT cycles in a row. Accept responses go only to the
// winner, and returning data tags are steered to the cache that owns them.
// Handshake: a request is taken when memory returns a non-zero response
// in the same cycle as the grant; a zero response (or losing arbitration)
// shows the requester a zero response, and it must hold and retry.
module mem_bus_arbiter
  import sys_defs::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
  parameter int NUM_MEM_TAGS = ARB_NUM_MEM_TAGS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  icache2arb_command,
  input  logic [63:0] icache2arb_addr,
  input  logic [1:0]  dcache2arb_command,
  input  logic [63:0] dcache2arb_addr,
  input  logic [63:0] dcache2arb_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [3:0]  mem2proc_tag,
  input  logic [63:0] mem2proc_data,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  output logic [3:0]  arb2icache_response,
  output logic [3:0]  arb2icache_tag,
  output logic [3:0]  arb2dcache_response,
  output logic [3:0]  arb2dcache_tag,
  output logic [63:0] arb2cache_data,
  output logic        grant_icache,
  output logic        arb_err
);

  localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             arb_err_q, arb_err_d;

  logic       icache_req, dcache_req, grant_dcache;
  logic       accepted, alloc_en, ret_valid, ret_hit;
  MEM_OWNER_t ret_entry;

  assign icache_req = (icache2arb_command != BUS_NONE);
  assign dcache_req = (dcache2arb_command != BUS_NONE);
  assign accepted   = (mem2proc_response != 4'h0);

  // Grant: Dcache has priority unless Icache has starved long enough.
  always_comb begin
    grant_icache = icache_req && (!dcache_req || (starve_cnt_q >= LIMIT_C));
    grant_dcache = dcache_req && !grant_icache;
  end

  // Request mux toward memory and accept-response routing to the winner.
  always_comb begin
    proc2mem_command    = BUS_NONE;
    proc2mem_addr       = 64'h0;
    proc2mem_data       = 64'h0;
    arb2icache_response = 4'h0;
    arb2dcache_response = 4'h0;
    if (grant_icache) begin
      proc2mem_command    = icache2arb_command;
      proc2mem_addr       = icache2arb_addr;
      arb2icache_response = mem2proc_response;
    end else if (grant_dcache) begin
      proc2mem_command    = dcache2arb_command;
      proc2mem_addr       = dcache2arb_addr;
      proc2mem_data       = dcache2arb_data;
      arb2dcache_response = mem2proc_response;
    end
  end

  // Only accepted loads create an outstanding tag; stores never return data.
  assign alloc_en = accepted && (proc2mem_command == BUS_LOAD);

  mem_owner_table #(
    .NUM_MEM_TAGS(NUM_MEM_TAGS)
  ) u_owner_table (
    .clock            (clock),
    .reset            (reset),
    .alloc_en_i       (alloc_en),
    .alloc_tag_i      (mem2proc_response),
    .alloc_is_icache_i(grant_icache),
    .free_en_i        (ret_hit),
    .lookup_tag_i     (mem2proc_tag),
    .lookup_entry_o   (ret_entry)
  );

  // Data-return steering: the owner sees the tag, the other cache sees 0.
  always_comb begin
    ret_valid      = (mem2proc_tag != 4'h0);
    ret_hit        = ret_valid && ret_entry.valid;
    arb2icache_tag = 4'h0;
    arb2dcache_tag = 4'h0;
    if (ret_hit) begin
      if (ret_entry.is_icache) begin
        arb2icache_tag = mem2proc_tag;
      end else begin
        arb2dcache_tag = mem2proc_tag;
      end
    end
    arb_err_d = arb_err_q || (ret_valid && !ret_entry.valid);
  end

  assign arb2cache_data = mem2proc_data;
  assign arb_err        = arb_err_q;

  // Starvation count: cleared when Icache is idle or served, else saturating.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!icache_req || (grant_icache && accepted)) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_MAX) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // State registers: starvation counter and sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= '0;
      arb_err_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      arb_err_q    <= arb_err_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: each task drives one scenario and
// checks outputs against hand-computed values mid-cycle.
module tb_mem_bus_arbiter;

  localparam logic [1:0] C_NONE  = 2'h0;
  localparam logic [1:0] C_LOAD  = 2'h1;
  localparam logic [1:0] C_STORE = 2'h2;

  logic        clock;
  logic        reset;
  logic [1:0]  icache2arb_command;
  logic [63:0] icache2arb_addr;
  logic [1:0]  dcache2arb_command;
  logic [63:0] dcache2arb_addr;
  logic [63:0] dcache2arb_data;
  logic [3:0]  mem2proc_response;
  logic [3:0]  mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  arb2icache_response;
  logic [3:0]  arb2icache_tag;
  logic [3:0]  arb2dcache_response;
  logic [3:0]  arb2dcache_tag;
  logic [63:0] arb2cache_data;
  logic        grant_icache;
  logic        arb_err;

  int compared;
  int mismatched;

  mem_bus_arbiter dut (
    .clock              (clock),
    .reset              (reset),
    .icache2arb_command (icache2arb_command),
    .icache2arb_addr    (icache2arb_addr),
    .dcache2arb_command (dcache2arb_command),
    .dcache2arb_addr    (dcache2arb_addr),
    .dcache2arb_data    (dcache2arb_data),
    .mem2proc_response  (mem2proc_response),
    .mem2proc_tag       (mem2proc_tag),
    .mem2proc_data      (mem2proc_data),
    .proc2mem_command   (proc2mem_command),
    .proc2mem_addr      (proc2mem_addr),
    .proc2mem_data      (proc2mem_data),
    .arb2icache_response(arb2icache_response),
    .arb2icache_tag     (arb2icache_tag),
    .arb2dcache_response(arb2dcache_response),
    .arb2dcache_tag     (arb2dcache_tag),
    .arb2cache_data     (arb2cache_data),
    .grant_icache       (grant_icache),
    .arb_err            (arb_err)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  // Advance to just after the next rising edge, so new inputs apply to the
  // following cycle and checks land mid-cycle.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] icmd, input logic [63:0] iaddr,
                       input logic [1:0] dcmd, input logic [63:0] daddr,
                       input logic [63:0] ddata, input logic [3:0] resp,
                       input logic [3:0] tag, input logic [63:0] mdata);
    icache2arb_command = icmd;
    icache2arb_addr    = iaddr;
    dcache2arb_command = dcmd;
    dcache2arb_addr    = daddr;
    dcache2arb_data    = ddata;
    mem2proc_response  = resp;
    mem2proc_tag       = tag;
    mem2proc_data      = mdata;
    #2;
  endtask

  task automatic drive_idle();
    drive(C_NONE, 64'h0, C_NONE, 64'h0, 64'h0, 4'h0, 4'h0, 64'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    next_cycle();
    next_cycle();
    drive_idle();
    compared++;
    if (proc2mem_command !== C_NONE || arb_err !== 1'b0 || grant_icache !== 1'b0) begin
      $display("FAIL reset_state: cmd=%0h err=%0b grant_i=%0b, required cmd=0 err=0 grant_i=0",
               proc2mem_command, arb_err, grant_icache);
      mismatched++;
    end
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_icache_load();
    drive(C_LOAD, 64'h100, C_NONE, 64'h0, 64'h0, 4'd3, 4'h0, 64'h0);
    compared++;
    if (proc2mem_command !== C_LOAD || proc2mem_addr !== 64'h100 || grant_icache !== 1'b1) begin
      $display("FAIL icache_grant: cmd=%0h addr=%0h grant_i=%0b, required cmd=1 addr=100 grant_i=1",
               proc2mem_command, proc2mem_addr, grant_icache);
      mismatched++;
    end
    compared++;
    if (arb2icache_response !== 4'd3 || arb2dcache_response !== 4'd0) begin
      $display("FAIL icache_resp: i_resp=%0d d_resp=%0d, required 3 / 0",
               arb2icache_response, arb2dcache_response);
      mismatched++;
    end
    next_cycle();
    drive_idle();
    next_cycle();
    drive(C_NONE, 64'h0, C_NONE, 64'h0, 64'h0, 4'h0, 4'd3, 64'hDEAD);
    compared++;
    if (arb2icache_tag !== 4'd3 || arb2dcache_tag !== 4'd0 || arb2cache_data !== 64'hDEAD) begin
      $display("FAIL icache_return: i_tag=%0d d_tag=%0d data=%0h, required 3 / 0 / dead",
               arb2icache_tag, arb2dcache_tag, arb2cache_data);
      mismatched++;
    end
    next_cycle();
    drive_idle();
    compared++;
    if (arb_err !== 1'b0) begin
      $display("FAIL icache_return_err: arb_err=%0b, required 0", arb_err);
      mismatched++;
    end
    // Tag 3 was freed: a second return of it is an error, cleared later by reset.
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [3:0] resp_tab [6];
    logic       exp_gi   [6];
    resp_tab = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd8, 4'd10};
    exp_gi   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 6; c++) begin
      drive(C_LOAD, 64'h300, C_LOAD, 64'h400, 64'h0, resp_tab[c], 4'h0, 64'h0);
      compared++;
      if (grant_icache !== exp_gi[c] ||
          proc2mem_addr !== (exp_gi[c] ? 64'h300 : 64'h400) ||
          arb2icache_response !== (exp_gi[c] ? resp_tab[c] : 4'h0) ||
          arb2dcache_response !== (exp_gi[c] ? 4'h0 : resp_tab[c])) begin
        $display("FAIL b2b_cycle%0d: grant_i=%0b addr=%0h i_resp=%0d d_resp=%0d, required grant_i=%0b",
                 c, grant_icache, proc2mem_addr, arb2icache_response, arb2dcache_response, exp_gi[c]);
        mismatched++;
      end
      next_cycle();
    end
    // Owners: tag 8 -> Icache, tag 1 -> Dcache.
    drive(C_NONE, 64'h0, C_NONE, 64'h0, 64'h0, 4'h0, 4'd8, 64'h88);
    compared++;
    if (arb2icache_tag !== 4'd8 || arb2dcache_tag !== 4'd0) begin
      $display("FAIL b2b_ret8: i_tag=%0d d_tag=%0d, required 8 / 0", arb2icache_tag, arb2dcache_tag);
      mismatched++;
    end
    next_cycle();
    drive(C_NONE, 64'h0, C_NONE, 64'h0, 64'h0, 4'h0, 4'd1, 64'h11);
    compared++;
    if (arb2icache_tag !== 4'd0 || arb2dcache_tag !== 4'd1) begin
      $display("FAIL b2b_ret1: i_tag=%0d d_tag=%0d, required 0 / 1", arb2icache_tag, arb2dcache_tag);
      mismatched++;
    end
    next_cycle();
    drive_idle();
    next_cycle();
  endtask

  task automatic test_same_cycle_realloc();
    drive(C_LOAD, 64'h700, C_NONE, 64'h0, 64'h0, 4'd7, 4'h0, 64'h0);
    next_cycle();
    drive(C_NONE, 64'h0, C_LOAD, 64'h710, 64'h0, 4'd7, 4'd7, 64'h77);
    compared++;
    if (arb2icache_tag !== 4'd7 || arb2dcache_tag !== 4'd0 || arb2dcache_response !== 4'd7) begin
      $display("FAIL realloc_ret: i_tag=%0d d_tag=%0d d_resp=%0d, required 7 / 0 / 7",
               arb2icache_tag, arb2dcache_tag, arb2dcache_response);
      mismatched++;
    end
    next_cycle();
    drive(C_NONE, 64'h0, C_NONE, 64'h0, 64'h0, 4'h0, 4'd7, 64'h78);
    compared++;
    if (arb2icache_tag !== 4'd0 || arb2dcache_tag !== 4'd7) begin
      $display("FAIL realloc_owner: i_tag=%0d d_tag=%0d, required 0 / 7", arb2icache_tag, arb2dcache_tag);
      mismatched++;
    end
    next_cycle();
    drive_idle();
    compared++;
    if (arb_err !== 1'b0) begin
      $display("FAIL realloc_err: arb_err=%0b, required 0", arb_err);
      mismatched++;
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    // Ten rejected cycles drive the counter to saturation; wrapping would
    // drop it below the limit and hand the port back to Dcache.
    for (int c = 0; c < 10; c++) begin
      drive(C_LOAD, 64'h500, C_NONE, 64'h0, 64'h0, 4'h0, 4'h0, 64'h0);
      compared++;
      if (grant_icache !== 1'b1 || arb2icache_response !== 4'h0) begin
        $display("FAIL starve_reject%0d: grant_i=%0b i_resp=%0d, required 1 / 0",
                 c, grant_icache, arb2icache_response);
        mismatched++;
      end
      next_cycle();
    end
    drive(C_LOAD, 64'h500, C_LOAD, 64'h600, 64'h0, 4'h0, 4'h0, 64'h0);
    compared++;
    if (grant_icache !== 1'b1 || proc2mem_addr !== 64'h500) begin
      $display("FAIL starve_priority: grant_i=%0b addr=%0h, required 1 / 500", grant_icache, proc2mem_addr);
      mismatched++;
    end
    next_cycle();
    drive(C_LOAD, 64'h500, C_LOAD, 64'h600, 64'h0, 4'd11, 4'h0, 64'h0);
    compared++;
    if (grant_icache !== 1'b1 || arb2icache_response !== 4'd11 || arb2dcache_response !== 4'd0) begin
      $display("FAIL starve_accept: grant_i=%0b i_resp=%0d d_resp=%0d, required 1 / 11 / 0",
               grant_icache, arb2icache_response, arb2dcache_response);
      mismatched++;
    end
    next_cycle();
    drive(C_LOAD, 64'h500, C_LOAD, 64'h600, 64'h0, 4'd12, 4'h0, 64'h0);
    compared++;
    if (grant_icache !== 1'b0 || arb2dcache_response !== 4'd12) begin
      $display("FAIL starve_cleared: grant_i=%0b d_resp=%0d, required 0 / 12", grant_icache, arb2dcache_response);
      mismatched++;
    end
    next_cycle();
    drive_idle();
    next_cycle();
  endtask

  task automatic test_store_err();
    drive(C_NONE, 64'h0, C_STORE, 64'h200, 64'h55, 4'd5, 4'h0, 64'h0);
    compared++;
    if (proc2mem_command !== C_STORE || proc2mem_addr !== 64'h200 ||
        proc2mem_data !== 64'h55 || arb2dcache_response !== 4'd5) begin
      $display("FAIL store_mux: cmd=%0h addr=%0h data=%0h d_resp=%0d, required 2 / 200 / 55 / 5",
               proc2mem_command, proc2mem_addr, proc2mem_data, arb2dcache_response);
      mismatched++;
    end
    next_cycle();
    drive_idle();
    next_cycle();
    drive(C_NONE, 64'h0, C_NONE, 64'h0, 64'h0, 4'h0, 4'd5, 64'h5);
    compared++;
    if (arb2icache_tag !== 4'd0 || arb2dcache_tag !== 4'd0) begin
      $display("FAIL store_ret_tags: i_tag=%0d d_tag=%0d, required 0 / 0", arb2icache_tag, arb2dcache_tag);
      mismatched++;
    end
    next_cycle();
    drive_idle();
    compared++;
    if (arb_err !== 1'b1) begin
      $display("FAIL store_ret_err: arb_err=%0b, required 1", arb_err);
      mismatched++;
    end
    next_cycle();
  endtask

  task automatic test_reset_clear();
    drive(C_LOAD, 64'h20, C_NONE, 64'h0, 64'h0, 4'd2, 4'h0, 64'h0);
    next_cycle();
    drive(C_NONE, 64'h0, C_LOAD, 64'h90, 64'h0, 4'd9, 4'h0, 64'h0);
    next_cycle();
    reset = 1'b1;
    drive_idle();
    next_cycle();
    reset = 1'b0;
    drive_idle();
    compared++;
    if (arb_err !== 1'b0 || proc2mem_command !== C_NONE) begin
      $display("FAIL reset_clear: arb_err=%0b cmd=%0h, required 0 / 0", arb_err, proc2mem_command);
      mismatched++;
    end
    next_cycle();
    drive(C_NONE, 64'h0, C_NONE, 64'h0, 64'h0, 4'h0, 4'd2, 64'h2);
    compared++;
    if (arb2icache_tag !== 4'd0 || arb2dcache_tag !== 4'd0) begin
      $display("FAIL reset_ret_tags: i_tag=%0d d_tag=%0d, required 0 / 0", arb2icache_tag, arb2dcache_tag);
      mismatched++;
    end
    next_cycle();
    drive_idle();
    compared++;
    if (arb_err !== 1'b1) begin
      $display("FAIL reset_ret_err: arb_err=%0b, required 1", arb_err);
      mismatched++;
    end
    next_cycle();
  endtask

  // Scenario sequence and final report
  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_icache_load();
    test_back_to_back();
    test_same_cycle_realloc();
    test_starvation();
    test_store_err();
    test_reset_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
